serial_paralelo_align: RTL and testbench

//  Receive-side deserializer on the clk_32f domain. Shifts in a 1-bit serial

---
 rtl/serpar_pkg.sv | 26 ++
 rtl/serpar_shift_detect.sv | 28 ++
 rtl/serial_paralelo_align.sv | 149 ++++++++++++++
 tb/tb_serial_paralelo_align.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/serpar_pkg.sv
// Shared definitions for the serial-to-parallel aligner: state encoding,
// idle comma default, lock thresholds and counter widths.
package serpar_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        LOCKING = 2'd1,
        SYNCED  = 2'd2
    } state_e;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned PH_W   = 3;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned MIS_W  = 4;

    localparam logic [BYTE_W-1:0] IDLE_SYMBOL_DEF    = 8'hBC;
    localparam int unsigned       LOCK_COUNT_DEF     = 4;
    localparam int unsigned       MISALIGN_COUNT_DEF = 4;

    // Increment that sticks at lim instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic [CNT_W-1:0] lim);
        return (v >= lim) ? lim : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/serpar_shift_detect.sv
// 8-bit MSB-first shift register with an idle-comma comparator on its contents.
module serpar_shift_detect
    import serpar_pkg::*;
#(
    parameter logic [BYTE_W-1:0] IDLE_SYMBOL = IDLE_SYMBOL_DEF
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              data_i,
    output logic [BYTE_W-1:0] sr_o,
    output logic              comma_hit_c_o
);

    logic [BYTE_W-1:0] sr_q;

    // Shift one serial bit in per clock, newest bit at the LSB.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sr_q <= '0;
        end else begin
            sr_q <= {sr_q[BYTE_W-2:0], data_i};
        end
    end

    assign sr_o          = sr_q;
    assign comma_hit_c_o = (sr_q == IDLE_SYMBOL);

endmodule

// File: rtl/serial_paralelo_align.sv
// Receive deserializer: hunts for the idle comma, locks after LOCK_COUNT
// aligned commas, then emits one byte per 8 clocks.
// Optional build macro SERPAR_REALIGN_EN: drop back to LOCKING after
// MISALIGN_COUNT off-phase commas while synced; without it SYNCED is sticky.
module serial_paralelo_align
    import serpar_pkg::*;
#(
    parameter logic [BYTE_W-1:0] IDLE_SYMBOL    = IDLE_SYMBOL_DEF,
    parameter int unsigned       LOCK_COUNT     = LOCK_COUNT_DEF
`ifdef SERPAR_REALIGN_EN
  , parameter int unsigned       MISALIGN_COUNT = MISALIGN_COUNT_DEF
`endif
) (
    input  logic              clk_32f,
    input  logic              reset,
    input  logic              data_in,
    output logic [BYTE_W-1:0] data_out,
    output logic              valid_out,
    output logic              byte_strobe,
    output logic              active
);

    logic [BYTE_W-1:0] sr;
    logic              comma_hit_c;

    state_e            state_q,     state_d;
    logic [PH_W-1:0]   ph_q,        ph_d;
    logic [CNT_W-1:0]  comma_cnt_q, comma_cnt_d;
    logic [BYTE_W-1:0] data_out_q,  data_out_d;
    logic              valid_q,     valid_d;
    logic              strobe_q,    strobe_d;
    logic              active_q,    active_d;
    logic              boundary_c;
    logic              update_c;
`ifdef SERPAR_REALIGN_EN
    logic [MIS_W-1:0]  mis_cnt_q,   mis_cnt_d;
`endif

    serpar_shift_detect #(
        .IDLE_SYMBOL (IDLE_SYMBOL)
    ) u_shift_detect (
        .clk_i         (clk_32f),
        .reset_i       (reset),
        .data_i        (data_in),
        .sr_o          (sr),
        .comma_hit_c_o (comma_hit_c)
    );

    // Alignment FSM, phase/comma counters and next output values.
    always_comb begin
        state_d     = state_q;
        ph_d        = ph_q + PH_W'(1);
        comma_cnt_d = comma_cnt_q;
`ifdef SERPAR_REALIGN_EN
        mis_cnt_d   = mis_cnt_q;
`endif
        boundary_c  = (ph_q == '0);

        case (state_q)
            HUNT: begin
                // Restart the phase so the next boundary lands 8 bits after the hit.
                if (comma_hit_c) begin
                    ph_d        = PH_W'(1);
                    comma_cnt_d = CNT_W'(1);
                    state_d     = LOCKING;
                end
            end
            LOCKING: begin
                if (boundary_c) begin
                    if (comma_hit_c) begin
                        comma_cnt_d = sat_inc(comma_cnt_q, CNT_W'(LOCK_COUNT));
                        if (comma_cnt_d == CNT_W'(LOCK_COUNT)) begin
                            state_d = SYNCED;
                        end
                    end else begin
                        comma_cnt_d = '0;
                        state_d     = HUNT;
                    end
                end
            end
            SYNCED: begin
`ifdef SERPAR_REALIGN_EN
                // Repeated commas at the wrong phase mean the byte grid has slipped.
                if (comma_hit_c) begin
                    if (boundary_c) begin
                        mis_cnt_d = '0;
                    end else if (mis_cnt_q + MIS_W'(1) == MIS_W'(MISALIGN_COUNT)) begin
                        mis_cnt_d   = '0;
                        ph_d        = PH_W'(1);
                        comma_cnt_d = CNT_W'(1);
                        state_d     = LOCKING;
                    end else begin
                        mis_cnt_d = mis_cnt_q + MIS_W'(1);
                    end
                end
`endif
            end
            default: begin
                state_d = HUNT;
            end
        endcase

        // The locking boundary itself already delivers the first byte.
        update_c   = boundary_c && (state_d == SYNCED);
        data_out_d = update_c ? sr : data_out_q;
        strobe_d   = update_c;
        active_d   = (state_d == SYNCED);
        if (update_c) begin
            valid_d = (sr != IDLE_SYMBOL);
        end else if (state_d == SYNCED) begin
            valid_d = valid_q;
        end else begin
            valid_d = 1'b0;
        end
    end

    // State, counters and output registers.
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state_q     <= HUNT;
            ph_q        <= '0;
            comma_cnt_q <= '0;
            data_out_q  <= '0;
            valid_q     <= 1'b0;
            strobe_q    <= 1'b0;
            active_q    <= 1'b0;
`ifdef SERPAR_REALIGN_EN
            mis_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            comma_cnt_q <= comma_cnt_d;
            data_out_q  <= data_out_d;
            valid_q     <= valid_d;
            strobe_q    <= strobe_d;
            active_q    <= active_d;
`ifdef SERPAR_REALIGN_EN
            mis_cnt_q   <= mis_cnt_d;
`endif
        end
    end

    assign data_out    = data_out_q;
    assign valid_out   = valid_q;
    assign byte_strobe = strobe_q;
    assign active      = active_q;

endmodule

// File: tb/tb_serial_paralelo_align.sv
// Self-checking bench for serial_paralelo_align: scoreboard of expected
// strobed bytes plus directed checks on lock, unlock, reset and slip.
module tb_serial_paralelo_align;
    import serpar_pkg::*;

    logic       clk_32f = 1'b0;
    logic       reset   = 1'b1;
    logic       data_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       byte_strobe;
    logic       active;

    serial_paralelo_align dut (
        .clk_32f     (clk_32f),
        .reset       (reset),
        .data_in     (data_in),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .byte_strobe (byte_strobe),
        .active      (active)
    );

    always #5 clk_32f = ~clk_32f;

    typedef struct packed {
        logic [7:0] data;
        logic       valid;
    } exp_t;

    typedef struct {
        logic [7:0] din;
        logic       exp_valid;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[8];
    int   n_vec       = 0;
    int   n_err       = 0;
    int   cyc         = 0;
    int   last_strobe = 0;
    bit   last_ok     = 1'b0;
    int   active_hits = 0;
    int   valid_hits  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk_32f);
        data_in = b;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            send_bit(b[i]);
        end
    endtask

    task automatic expect_byte(input logic [7:0] d, input logic v);
        sb_q.push_back({d, v});
    endtask

    task automatic do_reset(input int n);
        @(negedge clk_32f);
        reset = 1'b1;
        repeat (n) @(negedge clk_32f);
        reset   = 1'b0;
        data_in = 1'b0;
    endtask

    // Output monitor: every strobe pops one expected byte.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk_32f);
            cyc++;
            if (active)    active_hits++;
            if (valid_out) valid_hits++;
            if (!reset && byte_strobe) begin
                chk("strobe_active", 32'(active), 32'd1);
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_strobe: got data_out %0h, want no strobe (cycle %0d)",
                             data_out, cyc);
                end else begin
                    e = sb_q.pop_front();
                    chk("data_out", 32'(data_out), 32'(e.data));
                    chk("valid_out", 32'(valid_out), 32'(e.valid));
                end
                if (last_ok) chk("strobe_spacing", 32'(cyc - last_strobe), 32'd8);
                last_strobe = cyc;
                last_ok     = 1'b1;
            end
            if (!active) last_ok = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int a0;
        int v0;
        vecs[0] = '{8'h00, 1'b1};
        vecs[1] = '{8'hFF, 1'b1};
        vecs[2] = '{8'hBC, 1'b0};
        vecs[3] = '{8'h3C, 1'b1};
        vecs[4] = '{8'hA5, 1'b1};
        vecs[5] = '{8'h5A, 1'b1};
        vecs[6] = '{8'h81, 1'b1};
        vecs[7] = '{8'h7E, 1'b1};

        fork
            monitor();
        join_none

        // Reset held 3 cycles with toggling input.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_32f);
            chk("reset_outputs", 32'({data_out, valid_out, byte_strobe, active}), 32'd0);
            data_in = ~data_in;
        end
        reset   = 1'b0;
        data_in = 1'b0;
        @(negedge clk_32f);
        chk("state_after_reset", 32'(dut.state_q), 32'(HUNT));

        // Two commas then a non-comma at the boundary: back to HUNT.
        a0 = active_hits;
        v0 = valid_hits;
        send_byte(8'hBC);
        send_byte(8'hBC);
        send_byte(8'h12);
        repeat (2) @(negedge clk_32f);
        chk("t3_state", 32'(dut.state_q), 32'(HUNT));
        chk("t3_comma_cnt", 32'(dut.comma_cnt_q), 32'd0);
        chk("t3_active_seen", 32'(active_hits - a0), 32'd0);
        chk("t3_valid_seen", 32'(valid_hits - v0), 32'd0);

        do_reset(2);

        // Offset prefix, four commas, then data.
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_byte(8'hBC);
        expect_byte(8'hBC, 1'b0);
        send_byte(8'hBC);
        chk("t2_active_pre", 32'(active), 32'd0);
        expect_byte(8'hA5, 1'b1);
        send_byte(8'hA5);
        chk("t2_active_post", 32'(active), 32'd1);

        // Back-to-back data bytes from the table.
        for (int i = 0; i < 8; i++) begin
            expect_byte(vecs[i].din, vecs[i].exp_valid);
            send_byte(vecs[i].din);
        end

        // Stream slips by two bits, commas follow at the new phase.
        expect_byte(8'h00, 1'b1);
        send_byte(8'h00);
        expect_byte(8'hEF, 1'b1);
`ifdef SERPAR_REALIGN_EN
        for (int i = 0; i < 3; i++) expect_byte(8'h2F, 1'b1);
        for (int i = 0; i < 4; i++) expect_byte(8'hBC, 1'b0);
`else
        for (int i = 0; i < 9; i++) expect_byte(8'h2F, 1'b1);
`endif
        send_bit(1'b1);
        send_bit(1'b1);
        for (int k = 1; k <= 10; k++) begin
            send_byte(8'hBC);
`ifdef SERPAR_REALIGN_EN
            if (k == 4) begin
                fork
                    begin
                        repeat (2) @(negedge clk_32f);
                        chk("t6_active_drop", 32'(active), 32'd0);
                        chk("t6_state_locking", 32'(dut.state_q), 32'(LOCKING));
                    end
                join_none
            end
`endif
        end
        chk("t6_active_end", 32'(active), 32'd1);
        chk("t6_state_end", 32'(dut.state_q), 32'(SYNCED));

        // Reset pulse in the middle of a byte, then a fresh lock.
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        @(negedge clk_32f);
        reset   = 1'b1;
        data_in = 1'b1;
        @(negedge clk_32f);
        reset   = 1'b0;
        data_in = 1'b0;
        chk("t4_after_reset", 32'({data_out, valid_out, byte_strobe, active}), 32'd0);
        for (int i = 0; i < 3; i++) send_byte(8'hBC);
        expect_byte(8'hBC, 1'b0);
        send_byte(8'hBC);
        chk("t4_active_pre", 32'(active), 32'd0);
        expect_byte(8'h5A, 1'b1);
        send_byte(8'h5A);
        chk("t4_active_post", 32'(active), 32'd1);

        repeat (3) @(negedge clk_32f);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
